// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the ID stage of an in-order pipeline.
// Tracks the destination of every in-flight instruction in a DEPTH-entry
// shift scoreboard, selects a forwarding source for each ID operand, muxes
// the forwarded data, raises the load-use stall and keeps saturating
// stall/flush performance counters.
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int RBITS      = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [RBITS-1:0]           id_rs1,
  input  logic [RBITS-1:0]           id_rs2,
  input  logic                       id_use1,
  input  logic                       id_use2,
  input  logic [RBITS-1:0]           id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       flush,
  input  logic [XLEN-1:0]            rs1_data_i,
  input  logic [XLEN-1:0]            rs2_data_i,
  input  logic [DEPTH*XLEN-1:0]      fwd_data_i,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel1,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel2,
  output logic [XLEN-1:0]            op1_o,
  output logic [XLEN-1:0]            op2_o,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
);

  localparam int SELW = $clog2(DEPTH + 1);

  // Scoreboard entry k (1..DEPTH) describes the instruction in stage k.
  logic [DEPTH:1]            valid_q, valid_d;
  logic [DEPTH:1]            regwrite_q, regwrite_d;
  logic [DEPTH:1]            load_q, load_d;
  logic [DEPTH:1][RBITS-1:0] rd_q, rd_d;
  logic [31:0]               stall_cnt_q, stall_cnt_d;
  logic [31:0]               flush_cnt_q, flush_cnt_d;

  logic hazard1, hazard2;

  // Youngest-match search per operand; a too-young load becomes a hazard.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    hazard1  = 1'b0;
    hazard2  = 1'b0;
    // Walk oldest to youngest so the youngest match is the one that sticks.
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid && id_use1 && (id_rs1 != '0) && valid_q[k] && regwrite_q[k] &&
          (rd_q[k] == id_rs1)) begin
        fwd_sel1 = SELW'(k);
        hazard1  = load_q[k] && (k < LOAD_STAGE);
      end
      if (id_valid && id_use2 && (id_rs2 != '0) && valid_q[k] && regwrite_q[k] &&
          (rd_q[k] == id_rs2)) begin
        fwd_sel2 = SELW'(k);
        hazard2  = load_q[k] && (k < LOAD_STAGE);
      end
    end
    // Load data not yet available: fall back to the register file and stall.
    if (hazard1) fwd_sel1 = '0;
    if (hazard2) fwd_sel2 = '0;
    stall = id_valid && !flush && (hazard1 || hazard2);
  end

  // Operand muxes: register file unless a stage is selected.
  always_comb begin
    op1_o = rs1_data_i;
    op2_o = rs2_data_i;
    for (int k = 1; k <= DEPTH; k++) begin
      if (fwd_sel1 == SELW'(k)) op1_o = fwd_data_i[k*XLEN-1 -: XLEN];
      if (fwd_sel2 == SELW'(k)) op2_o = fwd_data_i[k*XLEN-1 -: XLEN];
    end
  end

  // Next scoreboard contents and counter values.
  always_comb begin
    for (int k = 2; k <= DEPTH; k++) begin
      valid_d[k]    = valid_q[k-1];
      regwrite_d[k] = regwrite_q[k-1];
      load_d[k]     = load_q[k-1];
      rd_d[k]       = rd_q[k-1];
    end
    // A stalled or squashed ID instruction enters EX as a bubble.
    valid_d[1]    = id_valid && !stall && !flush;
    regwrite_d[1] = id_regwrite;
    load_d[1]     = id_memread;
    rd_d[1]       = id_rd;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Scoreboard and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
    // NOTE: entry payload is left out of reset; valid_q alone qualifies it.
    regwrite_q <= regwrite_d;
    load_q     <= load_d;
    rd_q       <= rd_d;
  end

endmodule
